// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ requesters.
// Optional WAIT watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [2*N_REQ-1:0] req_baud,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_send,
    output logic [7:0]         tx_data,
    output logic [1:0]         tx_baud,
    input  logic               tx_done,
    output logic               busy,
    output logic               timeout_err
);

    localparam int          LW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     last_q, last_d;
    logic [LW-1:0]     win_q, win_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              tx_send_q, tx_send_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [1:0]        tx_baud_q, tx_baud_d;
    logic              timeout_q, timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]       wdog_q, wdog_d;
`else
    logic              unused_to_lim;
    assign unused_to_lim = ^TO_LIM;
`endif

    // Round-robin search starting just after the last served requester.
    logic              win_found;
    logic [LW-1:0]     win_idx;
    logic [7:0]        sel_data;
    logic [1:0]        sel_baud;
    int                idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sel_data  = '0;
        sel_baud  = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[LW-1:0];
                sel_data  = req_data[8*idx +: 8];
                sel_baud  = req_baud[2*idx +: 2];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        tx_baud_d = tx_baud_q;
        timeout_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wdog_d    = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = START;
                    win_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    tx_data_d      = sel_data;
                    tx_baud_d      = sel_baud;
                    tx_send_d      = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (tx_done) begin
                    state_d = IDLE;
                    ack_d   = gnt_q;
                    gnt_d   = '0;
                    last_d  = win_q;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (wdog_q == TO_LIM - 16'd1) begin
                    state_d   = IDLE;
                    ack_d     = gnt_q;
                    gnt_d     = '0;
                    last_d    = win_q;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= LW'(N_REQ - 1);
            win_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            tx_send_q <= 1'b0;
            tx_data_q <= '0;
            tx_baud_q <= 2'b00;
            timeout_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wdog_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            tx_send_q <= tx_send_d;
            tx_data_q <= tx_data_d;
            tx_baud_q <= tx_baud_d;
            timeout_q <= timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign tx_send     = tx_send_q;
    assign tx_data     = tx_data_q;
    assign tx_baud     = tx_baud_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_baud;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic [1:0]  tx_baud;
    logic        tx_done;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_baud(req_baud),
        .gnt(gnt), .ack(ack), .tx_send(tx_send), .tx_data(tx_data), .tx_baud(tx_baud),
        .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_baud = '0;
        tx_done  = 1'b0;
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_send", 32'(tx_send), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_baud", 32'(tx_baud), 0);
        chk("rst_to", 32'(timeout_err), 0);
        rst = 1'b0;
        tick();

        // Stray tx_done in IDLE
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_ack", 32'(ack), 0);
        chk("stray_busy", 32'(busy), 0);
        chk("stray_gnt", 32'(gnt), 0);

        // Single request on requester 2, dropped mid-transfer
        req      = 4'b0100;
        req_data = 32'h00A5_0000;
        req_baud = 8'b0010_0000;
        tick();
        chk("s_gnt", 32'(gnt), 32'h4);
        chk("s_send", 32'(tx_send), 1);
        chk("s_data", 32'(tx_data), 32'hA5);
        chk("s_baud", 32'(tx_baud), 2);
        chk("s_busy", 32'(busy), 1);
        req = 4'b0000;
        tick();
        chk("s_send_off", 32'(tx_send), 0);
        chk("s_gnt_hold", 32'(gnt), 32'h4);
        tick();
        chk("s_wait_noack", 32'(ack), 0);
        chk("s_wait_busy", 32'(busy), 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("s_ack", 32'(ack), 32'h4);
        chk("s_gnt_clr", 32'(gnt), 0);
        chk("s_idle", 32'(busy), 0);
        tick();
        chk("s_ack_pulse", 32'(ack), 0);

        // Fairness after reset: all four requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req      = 4'b1111;
        req_data = 32'h1312_1110;
        req_baud = 8'b11_10_01_00;
        for (int t = 0; t < 8; t++) begin
            exp_g = 4'b0001 << (t % 4);
            tick();
            chk("f_gnt", 32'(gnt), 32'(exp_g));
            chk("f_data", 32'(tx_data), 32'h10 + 32'(t % 4));
            chk("f_baud", 32'(tx_baud), 32'(t % 4));
            tick();
            chk("f_noack", 32'(ack), 0);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("f_ack", 32'(ack), 32'(exp_g));
            chk("f_idle", 32'(busy), 0);
        end

        // Data stability and single-requester re-grant
        req      = 4'b0001;
        req_data = 32'h0000_0011;
        tick();
        chk("d_gnt", 32'(gnt), 1);
        chk("d_data0", 32'(tx_data), 32'h11);
        req_data = 32'h0000_0022;
        tick();
        chk("d_data1", 32'(tx_data), 32'h11);
        tick();
        chk("d_data2", 32'(tx_data), 32'h11);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("d_ack", 32'(ack), 1);
        tick();
        chk("r_regrant", 32'(gnt), 1);
        chk("r_data", 32'(tx_data), 32'h22);

        // Reset mid-WAIT abandons transfer
        req = 4'b0000;
        tick();
        chk("m_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("m_gnt", 32'(gnt), 0);
        chk("m_busy", 32'(busy), 0);
        chk("m_ack", 32'(ack), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("m_ack2", 32'(ack), 0);
        req = 4'b0010;
        tick();
        chk("m_regnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();

`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("t_pending", 32'({timeout_err, ack}), 0);
        end
        tick();
        chk("t_err", 32'(timeout_err), 1);
        chk("t_ack", 32'(ack), 32'h2);
        chk("t_idle", 32'(busy), 0);
        tick();
        chk("t_err_pulse", 32'(timeout_err), 0);
`else
        for (int c = 0; c < 20; c++) tick();
        chk("n_wait_busy", 32'(busy), 1);
        chk("n_no_to", 32'(timeout_err), 0);
        chk("n_no_ack", 32'(ack), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("n_ack", 32'(ack), 32'h2);
        chk("n_idle", 32'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
